// File: rtl/periph_read_mux.sv
// Registered read-back mux between the CPU data bus and the peripheral bank.
// Optional WAIT timeout is built only when PERIPH_READ_TIMEOUT_EN is defined.
module periph_read_mux #(
  parameter int DATA_W   = 32,
  parameter int N_CH     = 8,
  parameter int SEL_W    = 3,
  parameter int ADDR_LSB = 2,
  parameter int TIMEOUT  = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_en,
  input  logic [31:0]              addr,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  input  logic [N_CH-1:0]          ch_ready,
  output logic [N_CH-1:0]          ch_rd_strobe,
  output logic [DATA_W-1:0]        read_data,
  output logic                     rd_valid,
  output logic                     rd_err,
  output logic                     busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam logic [SEL_W:0] NCH_L    = (SEL_W+1)'(N_CH);
  localparam logic [31:0]    SEL_MASK = ((32'd1 << SEL_W) - 32'd1) << ADDR_LSB;

  state_e              state_q;
  logic [SEL_W-1:0]    sel_q;
  logic [DATA_W-1:0]   read_data_q;
  logic                rd_valid_q;
  logic                rd_err_q;

  logic [SEL_W-1:0]    sel_s;
  logic                sel_mapped_s;
  logic                sel_ready_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic                timeout_s;
  logic                unused_addr_s;

  assign sel_s         = addr[ADDR_LSB +: SEL_W];
  assign sel_mapped_s  = ({1'b0, sel_s} < NCH_L);
  assign unused_addr_s = ^(addr & ~SEL_MASK);

`ifdef PERIPH_READ_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  // Counter holds the number of ready-less WAIT cycles already elapsed.
  assign timeout_s = (cnt_q == CNT_LAST);
`else
  assign timeout_s = 1'b0;
`endif

  // AND-OR select of the latched channel's ready bit and data word.
  always_comb begin
    sel_ready_s = 1'b0;
    sel_data_s  = '0;
    for (int k = 0; k < N_CH; k++) begin
      sel_ready_s = sel_ready_s | (ch_ready[k] & (sel_q == SEL_W'(k)));
      sel_data_s  = sel_data_s |
                    (ch_data[k*DATA_W +: DATA_W] & {DATA_W{sel_q == SEL_W'(k)}});
    end
  end

  // Pop strobe coincides with the capture edge so FIFOs advance exactly once.
  always_comb begin
    ch_rd_strobe = '0;
    for (int k = 0; k < N_CH; k++) begin
      ch_rd_strobe[k] = (state_q == ST_WAIT) && (sel_q == SEL_W'(k)) && ch_ready[k];
    end
  end

  // Read FSM with registered result and single-cycle valid/error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      read_data_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
`ifdef PERIPH_READ_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rd_en && sel_mapped_s) begin
            state_q <= ST_WAIT;
            sel_q   <= sel_s;
`ifdef PERIPH_READ_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end else if (rd_en) begin
            read_data_q <= '0;
            rd_valid_q  <= 1'b1;
            rd_err_q    <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (sel_ready_s) begin
            read_data_q <= sel_data_s;
            rd_valid_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end else if (timeout_s) begin
            read_data_q <= '0;
            rd_valid_q  <= 1'b1;
            rd_err_q    <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            state_q <= ST_WAIT;
`ifdef PERIPH_READ_TIMEOUT_EN
            cnt_q   <= cnt_q + CNT_W'(1);
`endif
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign read_data = read_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_err    = rd_err_q;
  assign busy      = (state_q == ST_WAIT);

endmodule

// File: tb/tb_periph_read_mux.sv
// Self-checking bench for periph_read_mux: per-read latency/data/strobe model
// derived from the transaction rules, randomized channel data and ready bits.
module tb_periph_read_mux;
  localparam int DATA_W   = 32;
  localparam int N_CH     = 6;
  localparam int SEL_W    = 3;
  localparam int ADDR_LSB = 2;
  localparam int TIMEOUT  = 15;
  localparam logic [31:0] SEL_MASK = 32'h0000_001C;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   rd_en;
  logic [31:0]            addr;
  logic [N_CH*DATA_W-1:0] ch_data;
  logic [N_CH-1:0]        ch_ready;
  logic [N_CH-1:0]        ch_rd_strobe;
  logic [DATA_W-1:0]      read_data;
  logic                   rd_valid;
  logic                   rd_err;
  logic                   busy;

  int errors = 0;
  int checks = 0;
  longint cyc = 0;
  logic [DATA_W-1:0] last_data = '0;

  periph_read_mux #(
    .DATA_W(DATA_W), .N_CH(N_CH), .SEL_W(SEL_W), .ADDR_LSB(ADDR_LSB), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .addr(addr), .ch_data(ch_data),
    .ch_ready(ch_ready), .ch_rd_strobe(ch_rd_strobe), .read_data(read_data),
    .rd_valid(rd_valid), .rd_err(rd_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: a read of channel sel whose ready rises after n WAIT cycles.
  function automatic bit exp_ok(input int sel, input int n);
    if (sel >= N_CH) return 1'b0;
`ifdef PERIPH_READ_TIMEOUT_EN
    if (n >= TIMEOUT) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic int exp_latency(input int sel, input int n);
    if (sel >= N_CH) return 1;
`ifdef PERIPH_READ_TIMEOUT_EN
    if (n >= TIMEOUT) return TIMEOUT + 1;
`endif
    return 2 + n;
  endfunction

  task automatic do_read(input int sel, input int n, input bit hold_en, output longint done_cyc);
    int lat;
    bit ok;
    logic [DATA_W-1:0] word [N_CH];
    logic [DATA_W-1:0] exp_data;
    logic [N_CH-1:0]   exp_strobe;
    lat = exp_latency(sel, n);
    ok  = exp_ok(sel, n);
    for (int k = 0; k < N_CH; k++) begin
      word[k] = $urandom;
      ch_data[k*DATA_W +: DATA_W] = word[k];
    end
    exp_data = '0;
    if (ok) exp_data = word[sel];
    rd_en = 1'b1;
    addr  = ($urandom & ~SEL_MASK) | (32'(sel) << ADDR_LSB);
    for (int c = 0; c < lat; c++) begin
      ch_ready = N_CH'($urandom);
      if (sel < N_CH) ch_ready[sel] = (c > n);
      if (c > 0 && !hold_en) rd_en = 1'b0;
      if (c > 0 && hold_en) addr = $urandom;
      @(negedge clk);
      exp_strobe = '0;
      if (ok && c == lat - 1) exp_strobe = N_CH'(1) << sel;
      checks++;
      if (ch_rd_strobe !== exp_strobe)
        $display("FAIL strobe sel=%0d cycle=%0d: got %h expected %h", sel, c, ch_rd_strobe, exp_strobe);
      if (ch_rd_strobe !== exp_strobe) errors++;
      checks++;
      if (busy !== (c > 0 && sel < N_CH)) begin
        errors++;
        $display("FAIL busy sel=%0d cycle=%0d: got %b expected %b", sel, c, busy, (c > 0 && sel < N_CH));
      end
      @(posedge clk); #1;
      if (c < lat - 1) begin
        checks++;
        if (rd_valid !== 1'b0 || read_data !== last_data) begin
          errors++;
          $display("FAIL early_valid sel=%0d cycle=%0d: got valid=%b data=%h expected valid=0 data=%h",
                   sel, c, rd_valid, read_data, last_data);
        end
      end
    end
    checks++;
    if (rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL rd_valid sel=%0d n=%0d: got %b expected 1", sel, n, rd_valid);
    end
    checks++;
    if (rd_err !== !ok) begin
      errors++;
      $display("FAIL rd_err sel=%0d n=%0d: got %b expected %b", sel, n, rd_err, !ok);
    end
    checks++;
    if (read_data !== exp_data) begin
      errors++;
      $display("FAIL read_data sel=%0d n=%0d: got %h expected %h", sel, n, read_data, exp_data);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_done sel=%0d: got %b expected 0", sel, busy);
    end
    last_data = exp_data;
    if (!hold_en) rd_en = 1'b0;
    done_cyc = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd_en = 1'(($urandom));
      addr = $urandom;
      for (int k = 0; k < N_CH; k++) ch_data[k*DATA_W +: DATA_W] = $urandom;
      ch_ready = N_CH'($urandom);
      @(negedge clk);
      checks++;
      if (read_data !== '0 || rd_valid !== 1'b0 || rd_err !== 1'b0 || busy !== 1'b0 || ch_rd_strobe !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got data=%h valid=%b err=%b busy=%b strobe=%h expected all 0",
                 read_data, rd_valid, rd_err, busy, ch_rd_strobe);
      end
    end
    rd_en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    rd_en = 1'b1;
    addr = 32'h0000_000C;
    ch_ready = '0;
    @(posedge clk); #1;
    rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_wait_busy: got %b expected 1", busy);
    end
    rst_n = 1'b0;
    ch_ready = '1;
    #1;
    checks++;
    if (busy !== 1'b0 || ch_rd_strobe !== '0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: got busy=%b strobe=%h valid=%b expected 0 0 0", busy, ch_rd_strobe, rd_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_data = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rd_valid !== 1'b0 || busy !== 1'b0 || read_data !== '0) begin
        errors++;
        $display("FAIL post_reset: got valid=%b busy=%b data=%h expected 0 0 0", rd_valid, busy, read_data);
      end
    end
  endtask

  task automatic test_basic();
    longint t;
    do_read(3, 0, 1'b0, t);
    do_read(1, 2, 1'b0, t);
  endtask

  task automatic test_unmapped();
    longint t;
    do_read(7, 0, 1'b0, t);
    do_read(6, 0, 1'b0, t);
    do_read(2, 0, 1'b0, t);
  endtask

  task automatic test_held_rd_en();
    longint t;
    do_read(1, 4, 1'b1, t);
    do_read(3, 0, 1'b0, t);
  endtask

  task automatic test_timeout();
    longint t;
    do_read(2, 100, 1'b0, t);
    do_read(2, TIMEOUT - 1, 1'b0, t);
    do_read(2, TIMEOUT, 1'b0, t);
  endtask

  task automatic test_back_to_back();
    longint t0, t1, t2;
    do_read(0, 0, 1'b0, t0);
    do_read(4, 0, 1'b0, t1);
    do_read(5, 0, 1'b0, t2);
    checks++;
    if (t1 - t0 != 2 || t2 - t1 != 2) begin
      errors++;
      $display("FAIL back_to_back_spacing: got %0d,%0d expected 2,2", t1 - t0, t2 - t1);
    end
  endtask

  task automatic test_random();
    longint t;
    int sel, n;
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 7);
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 5);
      do_read(sel, n, 1'($urandom_range(0, 1)), t);
      if ($urandom_range(0, 2) == 0) begin
        rd_en = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
          checks++;
          if (rd_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_gap: got valid=%b busy=%b expected 0 0", rd_valid, busy);
          end
        end
      end
    end
    rd_en = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    rd_en = 1'b0;
    addr = '0;
    ch_data = '0;
    ch_ready = '0;
    test_reset();
    test_basic();
    test_unmapped();
    test_held_rd_en();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/periph_read_mux.md
# periph_read_mux

Parametrised, registered read-back multiplexer between the processor data bus and the memory-mapped peripheral bank (ADC control/data, keypad, seven-segment, LEDs, switches, timer, spare slots). It decodes the channel from the read address and waits for the selected peripheral to signal ready. It returns registered read data with a one-cycle valid pulse. It also emits a per-channel read strobe so pop-on-read peripherals (keypad FIFO, ADC data) can advance.

## Interface
- DATA_W, 32, width of each channel word and of read_data
- N_CH, 8, number of peripheral channels (1..2^SEL_W)
- SEL_W, 3, channel-select field width
- ADDR_LSB, 2, lowest address bit of the select field
- TIMEOUT, 15, WAIT cycles before a read is aborted (used only with the timeout macro; ≥1)

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_en  in  1  read request, sampled only in IDLE
- addr  in  32  read address; sel = addr[ADDR_LSB+SEL_W-1:ADDR_LSB]
- ch_data  in  N_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
- ch_ready  in  N_CH  channel k data valid and readable
- ch_rd_strobe  out  N_CH  one-hot pulse when channel k's data is captured
- read_data  out  DATA_W  registered read result
- rd_valid  out  1  one-cycle pulse, read_data updated
- rd_err  out  1  qualifies rd_valid, high for unmapped or timed-out read
- busy  out  1  high when not in IDLE

## Operation
- States: IDLE, WAIT.
- IDLE, rd_en=1, sel < N_CH: latch sel_q=sel, clear timeout counter, go to WAIT.
- IDLE, rd_en=1, sel ≥ N_CH (unmapped): stay in IDLE. Next edge sets read_data=0, rd_valid=1, rd_err=1. No strobe.
- WAIT, ch_ready[sel_q]=1: read_data ← ch_data[sel_q], rd_valid=1, rd_err=0, go to IDLE.
- WAIT, ch_ready[sel_q]=0: stay; increment timeout counter (macro only).
- ch_rd_strobe[k] = (state==WAIT) & (k==sel_q) & ch_ready[k]. It is combinational and asserts in the same cycle as the capture edge. At most one bit is set.
- rd_en while busy=1 is ignored and is not queued. addr is sampled only with an accepted rd_en.
- read_data holds its last value between completions. rd_valid and rd_err are single-cycle pulses.
- Ready bits of channels other than sel_q have no effect.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, read_data=0, rd_valid=0, rd_err=0, busy=0, ch_rd_strobe=0, sel_q=0, counter=0.
- Reset mid-WAIT aborts the read. No rd_valid and no strobe are produced.
- Mapped read, ready already high: rd_en at edge E0, strobe during cycle E0–E1, rd_valid high after E1. Latency is 2 edges.
- Mapped read, ready rises n cycles into WAIT: latency is 2+n edges.
- Unmapped read: rd_valid/rd_err high after E0. Latency is 1 edge.
- Back-to-back: a new rd_en may be presented in the cycle rd_valid is high, because the block is already in IDLE. Sustained throughput is one mapped read per 2 cycles.

## Configuration
- PERIPH_READ_TIMEOUT_EN defined: the counter (width clog2(TIMEOUT+1)) counts WAIT cycles without ready.
  - After TIMEOUT such cycles the block returns to IDLE with read_data=0, rd_valid=1, rd_err=1 and no strobe. Total latency is TIMEOUT+1 edges.
  - If ready is high on the edge that would time out, ready wins (normal completion).
- PERIPH_READ_TIMEOUT_EN undefined: no counter is built. WAIT persists until ready or reset, and rd_err is set only for unmapped reads.

## Test plan
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Assert rst_n=0 mid-WAIT -> busy drops immediately, no rd_valid.
- N_CH=8, ch_data[3]=0xA5A5_0003, ch_ready=all 1, addr=0x0C, rd_en pulse -> ch_rd_strobe=0x08 for one cycle, then read_data=0xA5A5_0003, rd_valid=1, rd_err=0, 2 edges after request.
- N_CH=6, addr=0x1C (sel=7) -> after 1 edge: read_data=0, rd_valid=1, rd_err=1, ch_rd_strobe never set.
- sel=1 with ch_ready[1] rising after 4 WAIT cycles, rd_en held high throughout -> single completion at 6 edges; the extra rd_en while busy does not start a second read; next read is accepted on the rd_valid cycle.
- With PERIPH_READ_TIMEOUT_EN, TIMEOUT=15, ch_ready[2]=0 forever -> rd_valid=1, rd_err=1, read_data=0 at edge 16. Raising ready exactly at edge 16 -> normal completion with the data. Without the macro -> busy stays 1 for 100 cycles.
- Back-to-back reads of channels 0,4,6 with ready high -> rd_valid every 2 cycles, correct data, strobes 0x01, 0x10, 0x40 in order.
